// File: rtl/mem_control_unit_pkg.sv
// mem_control_unit_pkg
//   Shared ISA constants and bus widths for the memory-access steering block.
//   Holds the opcode map (including LDR/STR), the address/data/PC widths,
//   and a small decode helper used by the steering logic.
package mem_control_unit_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int OP_W   = 4;

  // Opcode map. Only LDR and STR touch memory through the data path; all
  // other opcodes leave the address bus on the fetch PC.
  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_ORR = 4'b0011;
  localparam logic [OP_W-1:0] OP_EOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_MOV = 4'b0101;
  localparam logic [OP_W-1:0] OP_CMP = 4'b0110;
  localparam logic [OP_W-1:0] OP_LSL = 4'b0111;
  localparam logic [OP_W-1:0] OP_LSR = 4'b1000;
  localparam logic [OP_W-1:0] OP_B   = 4'b1001;
  localparam logic [OP_W-1:0] OP_BEQ = 4'b1010;
  localparam logic [OP_W-1:0] OP_BNE = 4'b1011;
  localparam logic [OP_W-1:0] OP_NOP = 4'b1100;
  localparam logic [OP_W-1:0] OP_LDR = 4'b1101;
  localparam logic [OP_W-1:0] OP_STR = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // Memory direction as seen on the rw strobe.
  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_dir_e;

  // Zero-extend the fetch PC onto the memory address bus.
  function automatic logic [ADDR_W-1:0] pc_to_addr(input logic [PC_W-1:0] pc);
    return {{(ADDR_W-PC_W){1'b0}}, pc};
  endfunction

endpackage

// File: rtl/mem_control_unit_if.sv
// mem_control_unit_if
//   Bundle between the execute stage (master) and the memory steering unit
//   (slave).
//   master drives : pc, op_code, src1, src2, alu_result, mem_data_in
//   slave drives  : addr_mux_out, ldr_mux_out, rw, mem_data_out
interface mem_control_unit_if;
  import mem_control_unit_pkg::*;

  logic [PC_W-1:0]   pc;
  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data_in;

  logic [ADDR_W-1:0] addr_mux_out;
  logic [DATA_W-1:0] ldr_mux_out;
  logic              rw;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output pc, op_code, src1, src2, alu_result, mem_data_in,
    input  addr_mux_out, ldr_mux_out, rw, mem_data_out
  );

  modport slave (
    input  pc, op_code, src1, src2, alu_result, mem_data_in,
    output addr_mux_out, ldr_mux_out, rw, mem_data_out
  );

endinterface

// File: rtl/mem_control_unit.sv
// mem_control_unit
//   Memory-access steering between the execute stage and the unified
//   16-bit-addressed memory. Purely combinational, zero-cycle latency.
//   Ports:
//     clk    - system clock, kept for pipeline integration (no state here)
//     reset  - asynchronous active-low; while low, memory writes are blocked
//              and the outputs fall back to the fetch/ALU defaults
//     bus    - mem_control_unit_if.slave:
//                in : pc, op_code, src1, src2, alu_result, mem_data_in
//                out: addr_mux_out (memory address), ldr_mux_out (writeback),
//                     rw (0 read / 1 write), mem_data_out (store data)
module mem_control_unit
  import mem_control_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_control_unit_if.slave  bus
);

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wb;
  mem_dir_e          w_dir;
  logic [DATA_W-1:0] w_st_data;

  // clk has no consumer yet and the base register's upper half is dropped
  // by the 16-bit address bus; fold them here so they read as intentional.
  logic w_unused;
  assign w_unused = &{1'b0, clk, bus.src1[DATA_W-1:ADDR_W]};

  always_comb begin
    // Fetch/ALU defaults: address from PC, read, no store data, ALU writeback.
    w_addr    = pc_to_addr(bus.pc);
    w_wb      = bus.alu_result;
    w_dir     = MEM_RD;
    w_st_data = '0;

    // Reset gates the decode entirely, so a store can never reach memory
    // while reset is held. Unknown opcodes fall through to the defaults.
    if (reset) begin
      case (bus.op_code)
        OP_LDR: begin
          w_addr = bus.src1[ADDR_W-1:0];
          w_wb   = bus.mem_data_in;
        end
        OP_STR: begin
          w_addr    = bus.src1[ADDR_W-1:0];
          w_dir     = MEM_WR;
          w_st_data = bus.src2;
        end
        default: ;
      endcase
    end
  end

  assign bus.addr_mux_out = w_addr;
  assign bus.ldr_mux_out  = w_wb;
  assign bus.rw           = w_dir;
  assign bus.mem_data_out = w_st_data;

endmodule

// File: tb/tb_mem_control_unit.sv
module tb_mem_control_unit;
  import mem_control_unit_pkg::*;

  logic clk;
  logic reset;

  mem_control_unit_if bus ();

  mem_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wb;
    logic              rw;
    logic [DATA_W-1:0] mdo;
  } exp_t;

  exp_t q[$];
  event ev_sample;
  int   total = 0;
  int   bad   = 0;
  int   seen  = 0;

  // Monitor: whenever the stimulus marks the outputs as settled, pop the
  // expected response and check every output field.
  initial begin
    exp_t e;
    forever begin
      @(ev_sample);
      while (q.size() > 0) begin
        e = q.pop_front();
        seen++;
        total++;
        if (bus.addr_mux_out !== e.addr) begin
          bad++;
          $display("FAIL %s addr: got %h want %h", e.tag, bus.addr_mux_out, e.addr);
        end
        total++;
        if (bus.ldr_mux_out !== e.wb) begin
          bad++;
          $display("FAIL %s wb: got %h want %h", e.tag, bus.ldr_mux_out, e.wb);
        end
        total++;
        if (bus.rw !== e.rw) begin
          bad++;
          $display("FAIL %s rw: got %b want %b", e.tag, bus.rw, e.rw);
        end
        total++;
        if (bus.mem_data_out !== e.mdo) begin
          bad++;
          $display("FAIL %s mdo: got %h want %h", e.tag, bus.mem_data_out, e.mdo);
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] op, input logic [7:0] pc,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] alu, input logic [31:0] mdi);
    reset           = rst;
    bus.op_code     = op;
    bus.pc          = pc;
    bus.src1        = s1;
    bus.src2        = s2;
    bus.alu_result  = alu;
    bus.mem_data_in = mdi;
  endtask

  // Outputs settle combinationally; sample 1 time unit after driving.
  task automatic expect_out(input string tag, input logic [15:0] a, input logic [31:0] wb,
                            input logic rw, input logic [31:0] mdo);
    exp_t e;
    #1;
    e.tag = tag; e.addr = a; e.wb = wb; e.rw = rw; e.mdo = mdo;
    q.push_back(e);
    -> ev_sample;
    #1;
  endtask

  initial begin
    int pushed;
    pushed = 0;
    drive(1'b0, OP_STR, 8'h42, 32'h0001_0003, 32'h5, 32'hAAAA, 32'h0);
    @(posedge clk); #1;

    expect_out("rst_str", 16'h0042, 32'hAAAA, 1'b0, 32'h0); pushed++;

    drive(1'b0, OP_LDR, 8'h33, 32'h0000_9999, 32'h7, 32'h6, 32'h5);
    expect_out("rst_ldr", 16'h0033, 32'h6, 1'b0, 32'h0); pushed++;

    @(posedge clk); #1;
    drive(1'b1, OP_LDR, 8'h42, 32'h1, 32'h0, 32'hAAAA, 32'hFFFF_FFFF);
    expect_out("ldr_1", 16'h0001, 32'hFFFF_FFFF, 1'b0, 32'h0); pushed++;

    @(posedge clk); #1;
    drive(1'b1, OP_LDR, 8'h42, 32'h0000_8002, 32'h0, 32'hAAAA, 32'hFFFF_FFFE);
    expect_out("ldr_8002", 16'h8002, 32'hFFFF_FFFE, 1'b0, 32'h0); pushed++;

    @(posedge clk); #1;
    drive(1'b1, OP_STR, 8'h42, 32'h0001_0003, 32'h5, 32'h77, 32'h1234_5678);
    expect_out("str_trunc", 16'h0003, 32'h77, 1'b1, 32'h5); pushed++;

    @(posedge clk); #1;
    drive(1'b1, 4'b0000, 8'hFF, 32'h0000_4444, 32'h9, 32'h1234, 32'h8888);
    expect_out("alu_pcff", 16'h00FF, 32'h1234, 1'b0, 32'h0); pushed++;

    @(posedge clk); #1;
    drive(1'b1, OP_LDR, 8'h01, 32'hFFFF_FFFF, 32'h3, 32'h2, 32'h0);
    expect_out("ldr_ffff", 16'hFFFF, 32'h0, 1'b0, 32'h0); pushed++;

    @(posedge clk); #1;
    drive(1'b1, OP_STR, 8'h10, 32'h0, 32'hDEAD_BEEF, 32'h1, 32'h0);
    expect_out("str_addr0", 16'h0000, 32'h1, 1'b1, 32'hDEAD_BEEF); pushed++;

    @(posedge clk); #1;
    drive(1'b1, 4'b0x0x, 8'h10, 32'h0000_2222, 32'h5, 32'h99, 32'h77);
    expect_out("op_x", 16'h0010, 32'h99, 1'b0, 32'h0); pushed++;

    @(posedge clk); #1;
    drive(1'b1, OP_HLT, 8'h00, 32'h0000_3333, 32'h5, 32'h3, 32'h77);
    expect_out("op_f_pc0", 16'h0000, 32'h3, 1'b0, 32'h0); pushed++;

    // Reset toggled within a single clock period: no edge between samples.
    @(posedge clk); #1;
    drive(1'b1, OP_STR, 8'h20, 32'h0000_1234, 32'hCAFE, 32'h11, 32'h0);
    expect_out("mid_pre", 16'h1234, 32'h11, 1'b1, 32'hCAFE); pushed++;
    reset = 1'b0;
    expect_out("mid_rst", 16'h0020, 32'h11, 1'b0, 32'h0); pushed++;
    reset = 1'b1;
    expect_out("mid_rel", 16'h1234, 32'h11, 1'b1, 32'hCAFE); pushed++;

    @(posedge clk); #2;
    total++;
    if (q.size() != 0 || seen != pushed) begin
      bad++;
      $display("FAIL scoreboard: checked %0d of %0d, left %0d", seen, pushed, q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_control_unit.md
Name: mem_control_unit

Overview:
- Memory-access steering block between the execute stage and the unified 16-bit-addressed data/instruction memory.
- Selects the memory address: the instruction-fetch PC for ordinary instructions, or the register base address for LDR/STR.
- Drives the read/write strobe and the store data.
- Selects the register writeback value: loaded memory data for LDR, otherwise the ALU result.

Parameters:
- OP_LDR, 4'b1101, opcode of load (LDR dest, [src1]).
- OP_STR, 4'b1110, opcode of store (STR src2, [src1]).
- ADDR_W, 16, memory address width.
- DATA_W, 32, data/register width.
- PC_W, 8, program counter width.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- pc  input  8  current program counter (instruction fetch address).
- op_code  input  4  opcode of the instruction in the memory stage.
- src1  input  32  first source register value; the base address for LDR/STR.
- src2  input  32  second source register value; the store data for STR.
- alu_result  input  32  ALU output for non-load writeback.
- mem_data_in  input  32  data read from memory.
- addr_mux_out  output  16  memory address.
- ldr_mux_out  output  32  register writeback value.
- rw  output  1  memory direction: 0 = read, 1 = write.
- mem_data_out  output  32  data driven to memory on a write.

Behaviour:
- All outputs are combinational functions of the current inputs, with zero-cycle latency. No handshake.
- clk is present for pipeline integration only; no internal state is clocked in this revision.
- While reset is low (asserted) the outputs are forced immediately, independent of clk and op_code:
  - rw=0
  - mem_data_out=0
  - addr_mux_out={8'b0,pc}
  - ldr_mux_out=alu_result
- Writes therefore cannot occur during reset. Deasserting reset restores normal decode in the same delta.
- op_code==OP_LDR:
  - addr_mux_out=src1[15:0]; src1[31:16] is ignored (silent truncation, no fault).
  - rw=0, ldr_mux_out=mem_data_in, mem_data_out=0.
- op_code==OP_STR:
  - addr_mux_out=src1[15:0], rw=1, mem_data_out=src2.
  - ldr_mux_out=alu_result; it is not written back by the register file for STR.
- Any other op_code (fetch/ALU ops):
  - addr_mux_out={8'b0,pc}, rw=0, mem_data_out=0, ldr_mux_out=alu_result.
- X/Z on op_code: the default (non-memory) branch is taken, so rw stays 0.
- Boundaries:
  - src1=32'hFFFF_FFFF gives address 16'hFFFF.
  - pc=8'hFF gives address 16'h00FF.
  - Address zero is legal.
- No glitch filtering is required; downstream memory samples on clk.

Decomposition:
- Shared package holds OP_LDR, OP_STR and the other ISA opcodes, plus ADDR_W, DATA_W and PC_W.
- No sub-module is warranted; the address mux, writeback mux and rw decode are in one always_comb block.
- An optional reusable 2:1 mux is not required.

Test Plan:
- reset=0 with op_code=OP_STR, src2=5 -> rw=0, mem_data_out=0, addr_mux_out={8'b0,pc}.
- reset=1, op_code=OP_LDR, src1=32'h1, mem_data_in=32'hFFFF_FFFF -> rw=0, addr_mux_out=16'h0001, ldr_mux_out=32'hFFFF_FFFF, mem_data_out=0.
- reset=1, op_code=OP_LDR, src1=32'h0000_8002, mem_data_in=32'hFFFF_FFFE -> rw=0, addr_mux_out=16'h8002, ldr_mux_out=32'hFFFF_FFFE.
- reset=1, op_code=OP_STR, src1=32'h0001_0003, src2=32'h5 -> rw=1, addr_mux_out=16'h0003 (upper bits dropped), mem_data_out=32'h5.
- reset=1, op_code=4'b0000, pc=8'hFF, alu_result=32'h1234 -> rw=0, addr_mux_out=16'h00FF, ldr_mux_out=32'h1234, mem_data_out=0.
- Assert reset low while op_code=OP_STR mid-cycle -> rw falls to 0 immediately; releasing reset makes rw=1 again without waiting for a clock edge.
